// File: rtl/datapath_tr_multiciclo.sv
// datapath_tr_multiciclo
//   Multi-cycle TR datapath. Accepts one MIPS-format instruction at a time
//   over a valid/ready handshake. It executes R-type add/sub/and/or/slt, lw
//   and sw against an internal register bank and data RAM. The FSM walks
//   IDLE -> DEC -> EXE -> MEM -> WB. An illegal instruction leaves from DEC,
//   and sw leaves from MEM.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   TR        instruction word (opcode/rs/rt/rd/funct/imm)
//   tr_valid  TR is valid
//   tr_ready  block can accept an instruction (IDLE only)
//   done      one-cycle pulse when an instruction retires
//   illegal   one-cycle pulse with done for an unsupported opcode/funct
//   TR_ZF     zero flag of the last ALU result
//   result    last ALU result (registered)
//   dbg_addr  debug register index (wraps modulo REG_COUNT)
//   dbg_data  combinational read of register dbg_addr
module datapath_tr_multiciclo #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       TR,
    input  logic              tr_valid,
    output logic              tr_ready,
    output logic              done,
    output logic              illegal,
    output logic              TR_ZF,
    output logic [DATA_W-1:0] result,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_EXE,
        S_MEM,
        S_WB
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [31:0]       r_tr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_zf;
    logic [DATA_W-1:0] r_load;
    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic [DATA_W-1:0] r_ram  [MEM_DEPTH];

    logic [5:0]        w_op;
    logic [5:0]        w_fn;
    logic [RW-1:0]     w_rs;
    logic [RW-1:0]     w_rt;
    logic [RW-1:0]     w_rd;
    logic [DATA_W-1:0] w_imm;
    logic              w_is_r;
    logic              w_is_lw;
    logic              w_is_sw;
    logic              w_illegal;
    logic [DATA_W-1:0] w_alu;
    logic [AW-1:0]     w_addr;
    logic [RW-1:0]     w_wb_idx;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_accept;
    logic              w_ram_we;
    logic              w_load_en;
    logic              w_reg_we;

    // ---------------- decode (from the latched instruction) ----------------
    assign w_op    = r_tr[31:26];
    assign w_fn    = r_tr[5:0];
    assign w_rs    = r_tr[21 +: RW];
    assign w_rt    = r_tr[16 +: RW];
    assign w_rd    = r_tr[11 +: RW];
    assign w_imm   = DATA_W'($signed(r_tr[15:0]));
    assign w_is_lw = (w_op == OP_LW);
    assign w_is_sw = (w_op == OP_SW);

    always_comb begin
        w_is_r = 1'b0;
        if (w_op == OP_RTYPE) begin
            case (w_fn)
                FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_is_r = 1'b1;
                default:                               w_is_r = 1'b0;
            endcase
        end
    end

    assign w_illegal = !(w_is_r || w_is_lw || w_is_sw);

    // ---------------- ALU ----------------
    // lw/sw use the same adder for the effective address.
    always_comb begin
        w_alu = r_a + w_imm;
        if (w_is_r) begin
            case (w_fn)
                FN_SUB:  w_alu = r_a - r_b;
                FN_AND:  w_alu = r_a & r_b;
                FN_OR:   w_alu = r_a | r_b;
                FN_SLT:  w_alu = DATA_W'($signed(r_a) < $signed(r_b));
                default: w_alu = r_a + r_b;
            endcase
        end
    end

    assign w_addr    = r_result[AW-1:0];
    assign w_wb_idx  = w_is_lw ? w_rt : w_rd;
    assign w_wb_data = w_is_lw ? r_load : r_result;
    assign w_accept  = tr_ready && tr_valid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (tr_valid) w_next = S_DEC;
            S_DEC:   w_next = w_illegal ? S_IDLE : S_EXE;
            S_EXE:   w_next = S_MEM;
            S_MEM:   w_next = w_is_sw ? S_IDLE : S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Everything is masked while rst is high, so an instruction that is
    // abandoned by reset neither retires nor commits a write.
    always_comb begin
        tr_ready  = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        w_ram_we  = 1'b0;
        w_load_en = 1'b0;
        w_reg_we  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: tr_ready = 1'b1;
                S_DEC: begin
                    if (w_illegal) begin
                        done    = 1'b1;
                        illegal = 1'b1;
                    end
                end
                S_MEM: begin
                    w_load_en = w_is_lw;
                    if (w_is_sw) begin
                        w_ram_we = 1'b1;
                        done     = 1'b1;
                    end
                end
                S_WB: begin
                    w_reg_we = 1'b1;
                    done     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tr     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zf     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tr <= TR;
            end
            if (r_state == S_DEC) begin
                r_a <= r_regs[w_rs];
                r_b <= r_regs[w_rt];
            end
            if (r_state == S_EXE) begin
                r_result <= w_alu;
                r_zf     <= (w_alu == '0);
            end
        end
    end

    // ---------------- register bank ----------------
    // Entry 0 is cleared by reset and never written, so it always reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_we && (w_wb_idx != '0)) begin
            r_regs[w_wb_idx] <= w_wb_data;
        end
    end

    // ---------------- data RAM (not reset) ----------------
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_addr] <= r_b;
        end
        if (w_load_en) begin
            r_load <= r_ram[w_addr];
        end
    end

    assign TR_ZF    = r_zf;
    assign result   = r_result;
    assign dbg_data = r_regs[dbg_addr[RW-1:0]];

endmodule

// File: tb/tb_datapath_tr_multiciclo.sv
// tb_datapath_tr_multiciclo
//   Self-checking bench for datapath_tr_multiciclo. Directed scenarios from
//   the feature list come first, then randomized instructions. Every
//   instruction is checked against an instruction-level reference model
//   (register array, RAM array, last result/flag). The RAM is preloaded with
//   random words before reset so that loads can bring nonzero data into the
//   register bank.
module tb_datapath_tr_multiciclo;

    logic        clk;
    logic        rst;
    logic [31:0] TR;
    logic        tr_valid;
    logic        tr_ready;
    logic        done;
    logic        illegal;
    logic        TR_ZF;
    logic [31:0] result;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_ram  [64];
    logic [31:0] m_result;
    bit          m_zf;

    datapath_tr_multiciclo #(
        .DATA_W    (32),
        .REG_COUNT (32),
        .MEM_DEPTH (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .TR       (TR),
        .tr_valid (tr_valid),
        .tr_ready (tr_ready),
        .done     (done),
        .illegal  (illegal),
        .TR_ZF    (TR_ZF),
        .result   (result),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_result = '0;
        m_zf     = 1'b0;
    endtask

    // Instruction-level effect; returns retire cycle, illegal flag and the
    // register worth inspecting afterwards (-1 if none).
    task automatic model_exec(input logic [31:0] ins, output int cyc, output bit ill, output int tgt);
        logic [5:0]  op;
        logic [5:0]  fn;
        int          rs, rt, rd;
        logic [31:0] a, b, imm, r;
        op  = ins[31:26];
        fn  = ins[5:0];
        rs  = int'(ins[25:21]);
        rt  = int'(ins[20:16]);
        rd  = int'(ins[15:11]);
        a   = m_regs[rs];
        b   = m_regs[rt];
        imm = {{16{ins[15]}}, ins[15:0]};
        ill = 1'b0;
        tgt = -1;
        cyc = 0;
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
            case (fn)
                6'h20:   r = a + b;
                6'h22:   r = a - b;
                6'h24:   r = a & b;
                6'h25:   r = a | b;
                default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            endcase
            m_result = r;
            m_zf     = (r == 0);
            if (rd != 0) m_regs[rd] = r;
            tgt = rd;
            cyc = 4;
        end else if (op == 6'h23) begin
            r        = a + imm;
            m_result = r;
            m_zf     = (r == 0);
            if (rt != 0) m_regs[rt] = m_ram[r % 64];
            tgt = rt;
            cyc = 4;
        end else if (op == 6'h2B) begin
            r            = a + imm;
            m_result     = r;
            m_zf         = (r == 0);
            m_ram[r % 64] = b;
            cyc = 3;
        end else begin
            ill = 1'b1;
            tgt = rd;
            cyc = 1;
        end
    endtask

    task automatic run_instr(input logic [31:0] ins);
        int exp_cyc, tgt, cyc;
        bit exp_ill, got_ill;
        model_exec(ins, exp_cyc, exp_ill, tgt);
        @(negedge clk);
        check("ready_before", 32'(tr_ready), 32'd1);
        TR       = ins;
        tr_valid = 1'b1;
        @(posedge clk);
        #1;
        // keep offering junk while busy; it must be ignored
        TR      = $urandom;
        cyc     = 0;
        got_ill = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done) begin
                cyc     = k;
                got_ill = illegal;
                break;
            end
        end
        tr_valid = 1'b0;
        check("done_cycle", 32'(cyc), 32'(exp_cyc));
        check("illegal", 32'(got_ill), 32'(exp_ill));
        @(negedge clk);
        check("ready_after", 32'(tr_ready), 32'd1);
        check("done_low", 32'(done), 32'd0);
        check("result", result, m_result);
        check("zf", 32'(TR_ZF), 32'(m_zf));
        if (tgt >= 0) begin
            dbg_addr = 5'(tgt);
            #1;
            check("reg_target", dbg_data, m_regs[tgt]);
        end
        dbg_addr = 5'($urandom);
        #1;
        check("reg_random", dbg_data, m_regs[dbg_addr]);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  f;
        logic [5:0]  op;
        logic [5:0]  fns [5];
        int          sel;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
        w   = $urandom;
        sel = int'($urandom_range(0, 99));
        if (sel < 45) begin
            w[31:26] = 6'h00;
            w[5:0]   = fns[$urandom_range(0, 4)];
        end else if (sel < 70) begin
            w[31:26] = 6'h23;
        end else if (sel < 85) begin
            w[31:26] = 6'h2B;
        end else if (sel < 93) begin
            do f = 6'($urandom); while (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A);
            w[31:26] = 6'h00;
            w[5:0]   = f;
        end else begin
            do op = 6'($urandom); while (op == 6'h00 || op == 6'h23 || op == 6'h2B);
            w[31:26] = op;
        end
        return w;
    endfunction

    initial begin
        rst      = 1'b1;
        tr_valid = 1'b1;
        TR       = enc_r(1, 1, 10, 6'h20);
        dbg_addr = '0;
        // backdoor RAM preload (RAM has no reset)
        for (int i = 0; i < 64; i++) begin
            m_ram[i]       = $urandom;
            m_ram[i][31]   = (i % 3 == 0);
            dut.r_ram[i]   = m_ram[i];
        end
        m_ram[10] = 32'd7;
        m_ram[11] = 32'd7;
        dut.r_ram[10] = 32'd7;
        dut.r_ram[11] = 32'd7;
        model_reset();

        // reset with tr_valid held high: must not be accepted
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        tr_valid = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(tr_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_zf", 32'(TR_ZF), 32'd0);
        check("rst_result", result, 32'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check("rst_reg", dbg_data, 32'd0);
        end
        @(negedge clk);
        check("rst_ready_hold", 32'(tr_ready), 32'd1);

        // sw/lw/add from zeros
        run_instr(enc_i(6'h2B, 0, 0, 5));
        run_instr(enc_i(6'h23, 0, 3, 5));
        run_instr(enc_r(0, 0, 4, 6'h20));
        // nonzero data via memory
        run_instr(enc_i(6'h23, 0, 1, 10));
        run_instr(enc_i(6'h23, 0, 2, 11));
        run_instr(enc_r(1, 2, 5, 6'h22));
        run_instr(enc_r(0, 1, 6, 6'h2A));
        run_instr(enc_r(0, 6, 9, 6'h22));
        // illegal opcode with rd=$7
        run_instr({6'h3F, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20});
        // write to $0 discarded
        run_instr(enc_r(1, 1, 0, 6'h20));

        // reset during EXE of add $8,$1,$2
        @(negedge clk);
        TR       = enc_r(1, 2, 8, 6'h20);
        tr_valid = 1'b1;
        @(posedge clk);
        #1;
        tr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        tr_valid = 1'b1;
        TR       = enc_r(1, 1, 11, 6'h20);
        @(negedge clk);
        check("abort_done0", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_done1", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        tr_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check("abort_ready", 32'(tr_ready), 32'd1);
        check("abort_done2", 32'(done), 32'd0);
        check("abort_result", result, m_result);
        check("abort_zf", 32'(TR_ZF), 32'(m_zf));
        dbg_addr = 5'd8;
        #1;
        check("abort_reg8", dbg_data, 32'd0);
        @(negedge clk);
        check("abort_ready_hold", 32'(tr_ready), 32'd1);

        // fill registers with RAM contents, then random traffic
        for (int i = 1; i < 32; i++) begin
            run_instr(enc_i(6'h23, 0, i, 32 + i));
        end
        for (int n = 0; n < 200; n++) begin
            run_instr(rand_instr());
        end

        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check("final_reg", dbg_data, m_regs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
